// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-side and response signals of the shared-ALU arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
);
  logic                  flush;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [OP_WIDTH-1:0]   req0_op;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [OP_WIDTH-1:0]   req1_op;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [OP_WIDTH-1:0]   alu_opSel;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_overflow;
  logic                  alu_Z;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_z;
  logic                  rsp_overflow;

  modport slave (
    input  flush,
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output alu_a, alu_b, alu_opSel,
    input  alu_out, alu_overflow, alu_Z,
    output rsp_valid, rsp_id, rsp_result, rsp_z, rsp_overflow,
    input  rsp_ready
  );

  modport master (
    output flush,
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  alu_a, alu_b, alu_opSel,
    output alu_out, alu_overflow, alu_Z,
    input  rsp_valid, rsp_id, rsp_result, rsp_z, rsp_overflow,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with
// registered ALU inputs and a tagged, backpressurable response channel.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
) (
  input logic                clk,
  input logic                rstN,
  alu_share_arbiter_if.slave bus
);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q;
  logic                  grant_id_q;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q;
  logic [OP_WIDTH-1:0]   alu_op_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic                  rsp_id_q, rsp_z_q, rsp_ovf_q;

  logic can_grant, grant0, grant1, accept, capture;

  // Gating with rstN keeps both readies low for the whole reset interval.
  assign can_grant = rstN && (state_q == StIdle) && !bus.flush;
  assign grant0    = can_grant && bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign grant1    = can_grant && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
  assign accept    = grant0 || grant1;
  assign capture   = (state_q == StExec) && !bus.flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = bus.flush ? StIdle : StResp;
      // A completed transfer wins over a simultaneous flush.
      StResp: if (bus.rsp_ready || bus.flush) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_id_q     <= 1'b0;
      rsp_z_q      <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q      <= grant1 ? bus.req1_a  : bus.req0_a;
        alu_b_q      <= grant1 ? bus.req1_b  : bus.req0_b;
        alu_op_q     <= grant1 ? bus.req1_op : bus.req0_op;
        grant_id_q   <= grant1;
        last_grant_q <= grant1;
      end
      if (capture) begin
        rsp_result_q <= bus.alu_out;
        rsp_z_q      <= bus.alu_Z;
        rsp_ovf_q    <= bus.alu_overflow;
        rsp_id_q     <= grant_id_q;
      end
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_opSel    = alu_op_q;
  assign bus.rsp_valid    = (state_q == StResp);
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_z        = rsp_z_q;
  assign bus.rsp_overflow = rsp_ovf_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU closes the loop and a queue of
// expected responses is filled at accept time and drained at response time.
module tb_alu_share_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned OW = 4;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd4;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        z;
    logic        ovf;
  } rsp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  rsp_t sb_q[$];
  rsp_t alu_res;

  alu_share_arbiter_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic rsp_t alu_ref(logic id, logic [3:0] op, logic [31:0] a, logic [31:0] b);
    rsp_t r;
    r.id  = id;
    r.ovf = 1'b0;
    case (op)
      OP_ADD: begin
        r.result = a + b;
        r.ovf    = (a[31] == b[31]) && (r.result[31] != a[31]);
      end
      OP_SUB: begin
        r.result = a - b;
        r.ovf    = (a[31] != b[31]) && (r.result[31] != a[31]);
      end
      OP_AND:  r.result = a & b;
      4'd3:    r.result = a | b;
      OP_XOR:  r.result = a ^ b;
      default: r.result = 32'd0;
    endcase
    r.z = (r.result == 32'd0);
    return r;
  endfunction

  always_comb alu_res = alu_ref(1'b0, bus.alu_opSel, bus.alu_a, bus.alu_b);
  assign bus.alu_out      = alu_res.result;
  assign bus.alu_Z        = alu_res.z;
  assign bus.alu_overflow = alu_res.ovf;

  function automatic rsp_t observed();
    return {bus.rsp_id, bus.rsp_result, bus.rsp_z, bus.rsp_overflow};
  endfunction

  task automatic clear_inputs();
    bus.flush      = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_op    = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_op    = '0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b exp 00", {bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.rsp_valid, observed(), bus.alu_a, bus.alu_b, bus.alu_opSel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rsp_valid %b rsp %h alu_a %h alu_b %h op %h",
               bus.rsp_valid, observed(), bus.alu_a, bus.alu_b, bus.alu_opSel);
    end
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
    clear_inputs();
  endtask

  task automatic test_single_op();
    rsp_t exp, got;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'd5;
    bus.req0_b = 32'd3;
    bus.req0_op = OP_ADD;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: got %b exp 10", {bus.req0_ready, bus.req1_ready});
    end
    sb_q.push_back(alu_ref(1'b0, OP_ADD, 32'd5, 32'd3));
    @(negedge clk);
    bus.req0_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_opSel} !== {1'b0, 32'd5, 32'd3, OP_ADD}) begin
      errors++;
      $display("FAIL single_exec: rsp_valid %b alu_a %0d alu_b %0d op %0d exp 0 5 3 0",
               bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_opSel);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL single_rsp_valid: got %b exp 1 (queued %0d)", bus.rsp_valid, sb_q.size());
    end else begin
      exp = sb_q.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_rsp: got %h exp %h", got, exp);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: rsp_valid %b exp 0", bus.rsp_valid);
    end
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: req1_ready %b exp 1", bus.req1_ready);
    end
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_contention();
    int   grants[$];
    int   acc_cyc[$];
    int   nrsp = 0;
    int   cyc = 0;
    int   upd = -1;
    int   k0 = 0;
    int   k1 = 0;
    rsp_t exp, got;
    do_reset();
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'd10;
    bus.req0_b = 32'd3;
    bus.req0_op = OP_ADD;
    bus.req1_valid = 1'b1;
    bus.req1_a = 32'd100;
    bus.req1_b = 32'd0;
    bus.req1_op = OP_SUB;
    while (nrsp < 4 && cyc < 40) begin
      #1;
      if (bus.rsp_valid === 1'b1) begin
        got = observed();
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL contention_rsp: unexpected response %h", got);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL contention_rsp: got %h exp %h", got, exp);
          end
        end
        nrsp++;
      end
      if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin
        checks++;
        if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) begin
          errors++;
          $display("FAIL contention_onehot: got 11 exp one ready");
        end
        grants.push_back(bus.req1_ready ? 1 : 0);
        acc_cyc.push_back(cyc);
        if (bus.req1_ready) sb_q.push_back(alu_ref(1'b1, bus.req1_op, bus.req1_a, bus.req1_b));
        else                sb_q.push_back(alu_ref(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
        upd = bus.req1_ready ? 1 : 0;
      end
      @(negedge clk);
      cyc++;
      if (upd == 0) begin
        k0++;
        bus.req0_a = 32'd10 + 32'(k0);
      end else if (upd == 1) begin
        k1++;
        bus.req1_b = 32'(k1 * 7);
      end
      upd = -1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checks++;
    if (nrsp != 4 || grants.size() < 4) begin
      errors++;
      $display("FAIL contention_count: responses %0d grants %0d exp 4 4", nrsp, grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] != (i % 2)) begin
          errors++;
          $display("FAIL contention_order[%0d]: got %0d exp %0d", i, grants[i], i % 2);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
          errors++;
          $display("FAIL contention_spacing[%0d]: got %0d exp 3", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_t exp, first, got;
    @(negedge clk);
    clear_inputs();
    bus.req1_valid = 1'b1;
    bus.req1_a = 32'd7;
    bus.req1_b = 32'd7;
    bus.req1_op = OP_SUB;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: req1_ready %b exp 1", bus.req1_ready);
    end
    sb_q.push_back(alu_ref(1'b1, OP_SUB, 32'd7, 32'd7));
    @(negedge clk);
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'd1;
    bus.req0_b = 32'd1;
    bus.req0_op = OP_ADD;
    first = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = observed();
      checks++;
      if (i == 0) begin
        if (bus.rsp_valid !== 1'b1 || sb_q.size() == 0) begin
          errors++;
          $display("FAIL bp_rsp_valid: got %b exp 1", bus.rsp_valid);
        end else begin
          exp = sb_q.pop_front();
          first = exp;
          if (got !== exp) begin
            errors++;
            $display("FAIL bp_rsp: got %h exp %h", got, exp);
          end
        end
      end else if ({bus.rsp_valid, got} !== {1'b1, first}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid %b rsp %h exp 1 %h", i, bus.rsp_valid, got, first);
      end
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b exp 00", i, {bus.req0_ready, bus.req1_ready});
      end
      if (i == 5) bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req0_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: rsp_valid,req0_ready %b exp 01", {bus.rsp_valid, bus.req0_ready});
    end
    bus.req0_valid = 1'b0;
  endtask

  task automatic test_flush();
    rsp_t exp, got;
    int   xfers = 0;
    // Flush while the operation is executing.
    @(negedge clk);
    clear_inputs();
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'h0000_00f0;
    bus.req0_b = 32'h0000_003c;
    bus.req0_op = OP_AND;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_exec_accept: req0_ready %b exp 1", bus.req0_ready);
    end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_exec: rsp_valid,req1_ready %b exp 01", {bus.rsp_valid, bus.req1_ready});
    end
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_exec_norsp[%0d]: rsp_valid %b exp 0", i, bus.rsp_valid);
      end
    end
    // Flush together with rsp_ready while the response is presented.
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'h7fff_ffff;
    bus.req0_b = 32'd1;
    bus.req0_op = OP_ADD;
    #1;
    sb_q.push_back(alu_ref(1'b0, OP_ADD, 32'h7fff_ffff, 32'd1));
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    bus.flush = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    if (bus.rsp_valid === 1'b1) begin
      xfers++;
      got = observed();
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL flush_resp_data: unexpected response %h", got);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL flush_resp_data: got %h exp %h", got, exp);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.flush = 1'b0;
      if (bus.rsp_valid === 1'b1) xfers++;
    end
    checks++;
    if (xfers != 1) begin
      errors++;
      $display("FAIL flush_resp_once: transfers %0d exp 1", xfers);
    end
    // Flush in idle blocks the grant.
    bus.flush = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'h1234_5678;
    bus.req0_b = 32'h0f0f_0f0f;
    bus.req0_op = OP_XOR;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL flush_idle_ready: got %b exp 00", {bus.req0_ready, bus.req1_ready});
    end
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.req0_ready, bus.alu_a} !== {2'b00, 32'h7fff_ffff}) begin
      errors++;
      $display("FAIL flush_idle_hold: rsp_valid %b req0_ready %b alu_a %h exp 0 0 7fffffff",
               bus.rsp_valid, bus.req0_ready, bus.alu_a);
    end
    bus.flush = 1'b0;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_release: req0_ready %b exp 1", bus.req0_ready);
    end
    bus.req0_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    clear_inputs();
    bus.req0_valid = 1'b1;
    bus.req0_a = 32'h7fff_ffff;
    bus.req0_b = 32'd1;
    bus.req0_op = OP_ADD;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_overflow} !== 2'b11) begin
      errors++;
      $display("FAIL areset_pre: rsp_valid,ovf %b exp 11", {bus.rsp_valid, bus.rsp_overflow});
    end
    #2;
    rstN = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, observed(), bus.alu_a, bus.alu_b, bus.alu_opSel,
         bus.req0_ready, bus.req1_ready} !== '0) begin
      errors++;
      $display("FAIL areset_outputs: rsp_valid %b rsp %h alu_a %h alu_b %h op %h rdy %b exp all 0",
               bus.rsp_valid, observed(), bus.alu_a, bus.alu_b, bus.alu_opSel,
               {bus.req0_ready, bus.req1_ready});
    end
    sb_q.delete();
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL areset_first_grant: got %b exp 10", {bus.req0_ready, bus.req1_ready});
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL areset_norsp[%0d]: rsp_valid %b exp 0", i, bus.rsp_valid);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares a single combinational ALU between two requesters: requester 0 is the integer execute path and requester 1 is the branch/address-compute path. The block arbitrates round-robin, registers the winning operands and opcode onto the ALU input bus, and captures the ALU result, zero flag and overflow flag. It returns them on one tagged response channel with a valid/ready handshake. It sits between the decode/issue logic and the ALU instance, and owns every ALU input.

## Interface
Parameters:
- DATA_WIDTH, 32, width of operands and result
- OP_WIDTH, 4, width of the ALU operation select

Ports:
- clk  in  1  system clock, all state on rising edge
- rstN  in  1  asynchronous active-low reset
- flush  in  1  synchronous cancel of the in-flight operation
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands
- req0_op / req1_op  in  OP_WIDTH  ALU operation select
- alu_a, alu_b  out  DATA_WIDTH  registered operands to the ALU
- alu_opSel  out  OP_WIDTH  registered operation to the ALU
- alu_out  in  DATA_WIDTH  ALU result, combinational from alu_a/alu_b/alu_opSel
- alu_overflow, alu_Z  in  1  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester the response belongs to
- rsp_result  out  DATA_WIDTH  captured ALU result
- rsp_z, rsp_overflow  out  1  captured ALU flags

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant only when flush=0.
  - If exactly one reqN_valid=1, grant N.
  - If both are valid, grant the requester other than last_grant.
  - Granted reqN_ready=1 combinationally in the same cycle. The other requester's ready=0.
  - Handshake is valid && ready.
  - On handshake: register a, b, op into alu_a, alu_b, alu_opSel. Register N into grant_id and into last_grant. Go to EXEC.
- EXEC:
  - ALU inputs are stable.
  - If flush=1, go to IDLE and produce no response.
  - Otherwise, at the clock edge, capture alu_out, alu_Z, alu_overflow into rsp_result, rsp_z, rsp_overflow, and copy grant_id to rsp_id. Go to RESP.
- RESP:
  - rsp_valid=1. All rsp_* outputs are held stable.
  - If rsp_ready=1, the transfer completes and the FSM goes to IDLE. This holds even when flush=1, because a completed transfer is never cancelled.
  - Else if flush=1, go to IDLE and drop the response.
  - Else stay in RESP.
- reqN_ready is 0 in EXEC and RESP. Requesters must hold valid and operands stable until ready.
- alu_a, alu_b and alu_opSel keep their last values outside a new grant; they change only on a handshake.
- rsp_result, rsp_z, rsp_overflow and rsp_id keep their last captured values when rsp_valid=0.
- last_grant resets to 1, so requester 0 wins the first contention.
- No width conversion is done: ALU outputs are captured bit-exact.

## Timing
- Reset values: state=IDLE, req0_ready=req1_ready=0 while rstN=0, alu_a=alu_b=0, alu_opSel=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_z=0, rsp_overflow=0, last_grant=1.
- Reset assertion mid-operation returns to IDLE immediately. The in-flight operation is lost and no response is produced.
- Accept at edge T, then EXEC during T+1, then rsp_valid=1 from T+2.
- Latency is 2 cycles from accept to response.
- If rsp_ready=1 at T+2, state is IDLE at T+3 and the next accept can occur at T+3. Maximum throughput is 1 operation per 3 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate. Maximum wait is 1 foreign operation.
- Response backpressure is unbounded. rsp_* must not change while rsp_valid=1 and rsp_ready=0.

## Test plan
- Single op:
  - Stimulus: after reset, req0 a=5, b=3, op=ADD, rsp_ready=1.
  - Required: req0_ready in cycle 0; rsp_valid at cycle 2 with rsp_id=0, result=8, z=0; IDLE at cycle 3.
- Contention alternation:
  - Stimulus: both requesters valid continuously for 4 operations.
  - Required: grants in order 0,1,0,1; rsp_id sequence 0,1,0,1; one accept every 3 cycles.
- Backpressure:
  - Stimulus: req1 SUB a=7, b=7 with rsp_ready=0 for 5 cycles, then 1.
  - Required: rsp_valid held for 6 cycles with result=0, z=1, stable; both ready signals stay 0 until the cycle after the transfer.
- Flush:
  - Stimulus: flush in EXEC.
  - Required: no rsp_valid, IDLE next cycle.
  - Stimulus: flush and rsp_ready together in RESP.
  - Required: the response transfers exactly once.
  - Stimulus: flush in IDLE with req0_valid=1.
  - Required: req0_ready=0.
- Async reset:
  - Stimulus: deassert rstN mid-RESP, without waiting for a clock edge.
  - Required: rsp_valid=0 and all outputs at reset values immediately; after release, req0 wins the first contention.
